memory_access: RTL
==================

# memory_access

Memory-stage datapath and data-bus controller for the five-stage pipeline. It consumes the instruction held in the memory-stage pipeline register and issues at most one data-bus transaction per load/store. It aligns and extends load data, then produces the write-back bundle that the write-back register captures on its next edge. It stalls upstream stages while a transaction is outstanding.

## Interface
Parameters:
- XLEN, 64, datapath and address width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  memory-stage instruction valid
- in_pc  in  XLEN  instruction PC
- in_rd  in  5  destination register
- in_wen  in  1  register write enable
- in_alu  in  XLEN  ALU result; effective address for load/store
- in_store_data  in  XLEN  store source operand
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- in_size  in  2  0=B, 1=H, 2=W, 3=D
- in_unsigned  in  1  zero-extend load
- flush_M  in  1  squash the memory-stage instruction
- stall_W  in  1  write-back register is holding
- dreq_valid  out  1  data request valid
- dreq_addr  out  XLEN  byte address, unaligned form
- dreq_size  out  2  copy of the latched size
- dreq_strobe  out  8  byte write enables, 0 for loads
- dreq_data  out  XLEN  lane-shifted store data
- dresp_data_ok  in  1  response valid, one-cycle pulse
- dresp_data  in  XLEN  raw 64-bit response word
- stall_M  out  1  freeze memory stage and all earlier stages
- out_valid, out_pc, out_rd, out_wen, out_wdata  out  1/XLEN/5/1/XLEN  write-back bundle feeding the write-back register input
- misalign  out  1  misaligned access flagged with the bundle

## Operation
- FSM states: IDLE, BUSY, HOLD.
- **IDLE, non-memory instruction**
  - Bundle passes through combinationally, with out_wdata=in_alu.
  - out_valid=in_valid&!flush_M.
  - stall_M=0.
- **IDLE, memory op, aligned, !flush_M**
  - Latch addr, size, unsigned, rd, wen, pc, strobe and shifted data.
  - Next state BUSY. stall_M=1, out_valid=0.
- **Misaligned memory op** (addr mod 2^size ≠ 0)
  - No request is issued.
  - One-cycle pass-through with misalign=1, out_wen=0, out_wdata=in_alu, stall_M=0.
- **IDLE with flush_M=1**
  - No request. out_valid=0.
- **BUSY**
  - dreq_valid=1. All dreq_* signals are driven from latches and held stable.
  - stall_M=1.
  - On dresp_data_ok: capture the extended load result (0 for stores) into the result register. Next state HOLD.
- **HOLD**
  - Bundle is driven from the latches: out_valid=!dropped, out_wdata=result.
  - stall_M=0.
  - stall_W=0 → IDLE. stall_W=1 → remain in HOLD with outputs unchanged.
- **Flush during BUSY**
  - Set the dropped flag. The transaction still completes, because the bus cannot be aborted.
  - The HOLD cycle then drives out_valid=0.
- **Flush during HOLD**
  - out_valid=0 combinationally.
- **Store lanes**
  - dreq_data = store_data << (addr[2:0]*8).
  - dreq_strobe is 8'h01 (B), 8'h03 (H), 8'h0F (W) or 8'hFF (D), shifted left by addr[2:0].
- **Load extract**
  - field = dresp_data >> (addr[2:0]*8), truncated to the access size.
  - Sign-extend to XLEN unless in_unsigned=1. D ignores in_unsigned.

## Timing
- Reset low:
  - State is IDLE and all latches and flags are 0.
  - dreq_valid=0 immediately, asynchronously.
  - All outputs are 0 while reset is held.
- Reset mid-BUSY abandons the request. No response is expected afterwards.
- Non-memory ops have 0 added latency.
- Memory op, with the response in the k-th BUSY cycle (k≥1):
  - Accept cycle, then k BUSY cycles, then at least one HOLD cycle.
  - stall_M is high for exactly k+1 cycles.
- dreq_valid rises one cycle after accept and falls the cycle after dresp_data_ok.
- A dresp_data_ok outside BUSY is ignored.
- Only one transaction is in flight; no back-to-back requests without an IDLE cycle.

## Test plan
- **Non-memory pass-through:** ADD, in_alu=0x1234, rd=5 → same cycle out_valid=1, out_wdata=0x1234, stall_M=0, dreq_valid=0.
- **LB signed / LBU:**
  - addr=0x1003, dresp_data=0x00000000_80000000 in the first BUSY cycle → HOLD out_wdata=0xFFFFFFFF_FFFFFF80.
  - Same access with in_unsigned=1 → 0x80.
  - stall_M is high for 2 cycles.
- **SW lanes and latency:**
  - addr=0x1004, data=0x11223344_55667788 → dreq_data=0x55667788_00000000, strobe=0xF0.
  - dresp_data_ok delayed to the third BUSY cycle → stall_M high 4 cycles, dreq fields constant, out_wen=0.
- **Flush mid-transaction:** flush_M pulsed during BUSY → request still completes, HOLD out_valid=0, then IDLE.
- **Downstream stall in HOLD:** stall_W=1 for 2 cycles in HOLD → bundle held 3 cycles total, then IDLE on the first cycle with stall_W=0.
- **Misaligned access and reset:**
  - LW at 0x1002 → misalign=1, out_wen=0, no dreq_valid.
  - Reset asserted mid-BUSY → dreq_valid drops immediately, state is IDLE after release.

Source files
------------

// File: rtl/memory_access_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_if
// Description : Bundle of signals between the memory stage and its neighbours:
//               the incoming memory-stage instruction, the pipeline control
//               lines, the data-bus request/response pair and the write-back
//               bundle.
//               master : the memory-stage controller (memory_access)
//               slave  : the surrounding pipeline and data memory
// Revision    : 1.0  initial release
// ============================================================================
interface memory_access_if #(
    parameter int XLEN = 64
);
    // Memory-stage instruction
    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rd;
    logic            in_wen;
    logic [XLEN-1:0] in_alu;
    logic [XLEN-1:0] in_store_data;
    logic            in_mem_read;
    logic            in_mem_write;
    logic [1:0]      in_size;
    logic            in_unsigned;
    // Pipeline control
    logic            flush_M;
    logic            stall_W;
    logic            stall_M;
    // Data bus
    logic            dreq_valid;
    logic [XLEN-1:0] dreq_addr;
    logic [1:0]      dreq_size;
    logic [7:0]      dreq_strobe;
    logic [XLEN-1:0] dreq_data;
    logic            dresp_data_ok;
    logic [XLEN-1:0] dresp_data;
    // Write-back bundle
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd;
    logic            out_wen;
    logic [XLEN-1:0] out_wdata;
    logic            misalign;

    modport master (
        input  in_valid, in_pc, in_rd, in_wen, in_alu, in_store_data,
               in_mem_read, in_mem_write, in_size, in_unsigned,
               flush_M, stall_W, dresp_data_ok, dresp_data,
        output stall_M, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
               out_valid, out_pc, out_rd, out_wen, out_wdata, misalign
    );

    modport slave (
        output in_valid, in_pc, in_rd, in_wen, in_alu, in_store_data,
               in_mem_read, in_mem_write, in_size, in_unsigned,
               flush_M, stall_W, dresp_data_ok, dresp_data,
        input  stall_M, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
               out_valid, out_pc, out_rd, out_wen, out_wdata, misalign
    );
endinterface
`default_nettype wire

// File: rtl/memory_access.sv
`default_nettype none
// ============================================================================
// Module      : memory_access
// Description : Memory-stage datapath and data-bus controller. Issues at most
//               one bus transaction per load/store, aligns and extends load
//               data, and produces the write-back bundle. Stalls upstream
//               stages while a transaction is outstanding.
// Ports       : clk    - pipeline clock
//               reset  - asynchronous, active-low reset
//               bus    - memory_access_if.master (instruction in, data bus,
//                        pipeline control, write-back bundle out)
// Revision    : 1.0  initial release
// ============================================================================
module memory_access #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    memory_access_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_data;
    logic [XLEN-1:0] r_result;
    logic [1:0]      r_size;
    logic [4:0]      r_rd;
    logic [7:0]      r_strobe;
    logic            r_unsigned;
    logic            r_wen;
    logic            r_load;
    logic            r_dropped;

    logic            w_mem;
    logic            w_misalign;
    logic            w_accept;
    logic [7:0]      w_strobe_base;
    logic [7:0]      w_req_strobe;
    logic [XLEN-1:0] w_req_data;
    logic [XLEN-1:0] w_field;
    logic [XLEN-1:0] w_load_ext;

    assign w_mem = bus.in_valid & (bus.in_mem_read | bus.in_mem_write);

    // Address must be a multiple of the access size
    always_comb begin
        case (bus.in_size)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = bus.in_alu[0];
            2'd2:    w_misalign = |bus.in_alu[1:0];
            default: w_misalign = |bus.in_alu[2:0];
        endcase
    end

    always_comb begin
        case (bus.in_size)
            2'd0:    w_strobe_base = 8'h01;
            2'd1:    w_strobe_base = 8'h03;
            2'd2:    w_strobe_base = 8'h0F;
            default: w_strobe_base = 8'hFF;
        endcase
    end

    assign w_req_strobe = w_strobe_base << bus.in_alu[2:0];
    assign w_req_data   = bus.in_store_data << {bus.in_alu[2:0], 3'b000};

    // Load alignment uses the latched address so the response may arrive late
    assign w_field = bus.dresp_data >> {r_addr[2:0], 3'b000};

    always_comb begin
        case (r_size)
            2'd0: w_load_ext = r_unsigned ? {{(XLEN-8){1'b0}}, w_field[7:0]}
                                          : {{(XLEN-8){w_field[7]}}, w_field[7:0]};
            2'd1: w_load_ext = r_unsigned ? {{(XLEN-16){1'b0}}, w_field[15:0]}
                                          : {{(XLEN-16){w_field[15]}}, w_field[15:0]};
            2'd2: w_load_ext = r_unsigned ? {{(XLEN-32){1'b0}}, w_field[31:0]}
                                          : {{(XLEN-32){w_field[31]}}, w_field[31:0]};
            default: w_load_ext = w_field;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_pc       <= '0;
            r_data     <= '0;
            r_result   <= '0;
            r_size     <= 2'd0;
            r_rd       <= 5'd0;
            r_strobe   <= 8'h00;
            r_unsigned <= 1'b0;
            r_wen      <= 1'b0;
            r_load     <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr     <= bus.in_alu;
                r_pc       <= bus.in_pc;
                r_data     <= w_req_data;
                r_size     <= bus.in_size;
                r_rd       <= bus.in_rd;
                r_strobe   <= bus.in_mem_write ? w_req_strobe : 8'h00;
                r_unsigned <= bus.in_unsigned;
                // A store never writes the register file
                r_wen      <= bus.in_wen & ~bus.in_mem_write;
                r_load     <= ~bus.in_mem_write;
                r_dropped  <= 1'b0;
            end
            if ((r_state == BUSY) && bus.dresp_data_ok) begin
                r_result <= r_load ? w_load_ext : '0;
            end
            // The bus cannot be aborted, so a squash is remembered instead
            if (((r_state == BUSY) || (r_state == HOLD)) && bus.flush_M) begin
                r_dropped <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        w_accept        = 1'b0;
        bus.dreq_valid  = 1'b0;
        bus.dreq_addr   = r_addr;
        bus.dreq_size   = r_size;
        bus.dreq_strobe = r_strobe;
        bus.dreq_data   = r_data;
        bus.stall_M     = 1'b0;
        bus.out_valid   = 1'b0;
        bus.out_pc      = bus.in_pc;
        bus.out_rd      = bus.in_rd;
        bus.out_wen     = bus.in_wen;
        bus.out_wdata   = bus.in_alu;
        bus.misalign    = 1'b0;

        case (r_state)
            IDLE: begin
                if (!bus.flush_M) begin
                    if (w_mem && w_misalign) begin
                        bus.out_valid = 1'b1;
                        bus.out_wen   = 1'b0;
                        bus.misalign  = 1'b1;
                    end else if (w_mem) begin
                        w_accept    = 1'b1;
                        w_next      = BUSY;
                        bus.stall_M = 1'b1;
                    end else begin
                        bus.out_valid = bus.in_valid;
                    end
                end
            end
            BUSY: begin
                bus.dreq_valid = 1'b1;
                bus.stall_M    = 1'b1;
                if (bus.dresp_data_ok) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                bus.out_valid = ~r_dropped & ~bus.flush_M;
                bus.out_pc    = r_pc;
                bus.out_rd    = r_rd;
                bus.out_wen   = r_wen;
                bus.out_wdata = r_result;
                if (!bus.stall_W) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase

        // Outputs are forced quiet for as long as reset is held
        if (!reset) begin
            w_accept        = 1'b0;
            bus.dreq_valid  = 1'b0;
            bus.dreq_addr   = '0;
            bus.dreq_size   = 2'd0;
            bus.dreq_strobe = 8'h00;
            bus.dreq_data   = '0;
            bus.stall_M     = 1'b0;
            bus.out_valid   = 1'b0;
            bus.out_pc      = '0;
            bus.out_rd      = 5'd0;
            bus.out_wen     = 1'b0;
            bus.out_wdata   = '0;
            bus.misalign    = 1'b0;
        end
    end

endmodule
`default_nettype wire
